sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO with an internal register-array memory and power-of-two depth. It extends the basic push/pop FIFO with a full-range occupancy count, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through read mode. It also adds sticky overflow/underflow error flags and a synchronous flush. It sits between producer/consumer stages in the datapath wherever rate decoupling with early back-pressure is needed.

Parameters:
WIDTH, 64, data word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (default 16)
AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL; legal 1..DEPTH
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL; legal 0..DEPTH-1, AE_LEVEL < AF_LEVEL
FWFT, 0, read mode; 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
push  input  1  write request
pop  input  1  read request
flush  input  1  synchronous clear of FIFO contents
clr_err  input  1  synchronous clear of sticky error flags
data_in  input  WIDTH  write data
data_out  output  WIDTH  read data
data_valid  output  1  data_out holds a valid popped/head word
count  output  ADDR_W+1  occupancy, 0..DEPTH
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
overflow  output  1  sticky: push attempted and rejected
underflow  output  1  sticky: pop attempted and rejected

Behaviour:
- Reset (async): wr_ptr, rd_ptr, count = 0; data_out = 0; data_valid = 0; overflow = underflow = 0; fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0. Memory contents are not reset.
- rd_en = pop & !fifo_empty.
- wr_en = push & (!fifo_full | rd_en). Simultaneous push+pop while full: both are accepted and count is unchanged.
- Push+pop while empty: the push is accepted, the pop is rejected (underflow set), and count becomes 1.
- count next = count + wr_en - rd_en. It is computed at ADDR_W+1 bits and never wraps.
- Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
- Flags are decoded combinationally from the registered count, so they change in the same cycle count changes.
- overflow is set on push & !wr_en; underflow is set on pop & !rd_en. Both hold until clr_err=1 or reset.
- If clr_err and a new error occur in the same cycle, the flag is set (set wins).
- flush=1: wr_ptr, rd_ptr, count = 0 and data_valid = 0 next cycle. Push/pop in that cycle are ignored and do not raise errors. Error flags are unaffected by flush.
- FWFT=0 read path:
  - data_out is registered and loads mem[rd_ptr] on the clock edge where rd_en=1, giving 1-cycle read latency; otherwise it holds its value.
  - data_valid is a registered copy of rd_en.
- FWFT=1 read path:
  - data_out = mem[rd_ptr] when !fifo_empty, else 0.
  - data_valid = !fifo_empty.
  - A word pushed into an empty FIFO appears on data_out the cycle after the push edge. pop consumes the presented word.
- Write: mem[wr_ptr] <= data_in on wr_en. Same-cycle read of the same entry returns the old contents. This cannot occur for a valid head except at full, where rd_ptr == wr_ptr and the old word is the correct head.

Test Plan:
- Fill (defaults, FWFT=0): push 0x00..0x0F on 16 cycles. Required: count=16, fifo_full=1; almost_full rises when count reaches 12; a 17th push leaves count=16 and sets overflow=1.
- Drain: then pop 16 cycles. Required: data_out = 0x00..0x0F, each one cycle after its pop; fifo_empty=1; almost_empty=1 from count=4; a further pop sets underflow=1; clr_err clears both sticky flags.
- Full concurrency: at count=16, push 0xAA + pop for 1 cycle. Required: count stays 16, no overflow, popped word is the oldest entry, 0xAA is read last.
- Wrap-around: 40 cycles of interleaved push/pop keeping count between 3 and 9. Required: output order matches a reference queue exactly across pointer wrap, with no error flags.
- Flush/reset mid-operation:
  - With count=7, assert flush while also pushing. Required: count=0, fifo_empty=1, data_valid=0, the pushed word is discarded, error flags unchanged.
  - Assert rst asynchronously between clock edges. Required: all outputs go to reset values immediately.
- FWFT=1: push 0x55 into an empty FIFO. Required: data_out=0x55 and data_valid=1 the next cycle with no pop; then push 0x66 and pop once, after which data_out=0x66; a further pop gives fifo_empty=1 and data_out=0.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// Bundles the producer/consumer-facing signals of sync_fifo_flags.
//
// Handshake: push and pop are requests. They are not valid/ready pairs.
// A push is accepted when the FIFO is not full, or when a pop is accepted in
// the same cycle. A pop is accepted when the FIFO is not empty. A rejected
// request raises the matching sticky error flag (overflow / underflow).
// data_valid marks the cycles in which data_out carries a popped word
// (standard mode) or the current head word (first-word-fall-through mode).
interface sync_fifo_flags_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 4
);
  logic              push;
  logic              pop;
  logic              flush;
  logic              clr_err;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic              data_valid;
  logic [ADDR_W:0]   count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  // Producer/consumer side: issues requests and observes status.
  modport master (
    output push, pop, flush, clr_err, data_in,
    input  data_out, data_valid, count, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow, underflow
  );

  // FIFO side: services the requests and reports status.
  modport slave (
    input  push, pop, flush, clr_err, data_in,
    output data_out, data_valid, count, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with a register-array memory and a full-range occupancy
// count. It provides almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush. The read path is either
// registered (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo_flags #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic clk,
  input  logic rst,
  sync_fifo_flags_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_AF    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] L_AE    = (ADDR_W+1)'(AE_LEVEL);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_en;
  logic w_wr_en;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Status flags decode straight from the registered count.
  always_comb begin
    w_full  = (r_count == L_DEPTH);
    w_empty = (r_count == '0);
  end

  // Accept/reject decisions. A flush swallows both requests without errors.
  // A pop accepted at full frees a slot, so a push in the same cycle is
  // accepted too.
  always_comb begin
    w_rd_en   = bus.pop & ~w_empty & ~bus.flush;
    w_wr_en   = bus.push & (~w_full | w_rd_en) & ~bus.flush;
    w_ovf_evt = bus.push & ~w_wr_en & ~bus.flush;
    w_udf_evt = bus.pop & ~w_rd_en & ~bus.flush;
  end

  // Pointer and occupancy bookkeeping. The count is one bit wider than the
  // pointers, so it spans 0..DEPTH without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (ADDR_W+1)'(w_wr_en) - (ADDR_W+1)'(w_rd_en);
    end
  end

  // Memory write. Contents are not reset. A same-cycle read of this entry
  // sees the old word.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= bus.data_in;
  end

  // Sticky error flags. A new error wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt)        r_overflow  <= 1'b1;
      else if (bus.clr_err) r_overflow  <= 1'b0;
      if (w_udf_evt)        r_underflow <= 1'b1;
      else if (bus.clr_err) r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [WIDTH-1:0] r_data_out;
      logic             r_data_valid;

      // Registered read: one cycle of latency after an accepted pop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data_out   <= '0;
          r_data_valid <= 1'b0;
        end else begin
          if (w_rd_en) r_data_out <= r_mem[r_rd_ptr];
          r_data_valid <= w_rd_en;
        end
      end

      assign bus.data_out   = r_data_out;
      assign bus.data_valid = r_data_valid;
    end else begin : g_fwft_read
      // The head word is presented whenever the FIFO holds data.
      always_comb begin
        bus.data_out   = w_empty ? '0 : r_mem[r_rd_ptr];
        bus.data_valid = ~w_empty;
      end
    end
  endgenerate

  // Status outputs.
  always_comb begin
    bus.count        = r_count;
    bus.fifo_full    = w_full;
    bus.fifo_empty   = w_empty;
    bus.almost_full  = (r_count >= L_AF);
    bus.almost_empty = (r_count <= L_AE);
    bus.overflow     = r_overflow;
    bus.underflow    = r_underflow;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags. It drives a standard-read instance (u0) and a
// first-word-fall-through instance (u1), both with default geometry.
module tb_sync_fifo_flags;

  logic clk;
  logic rst;

  sync_fifo_flags_if #(.WIDTH(64), .ADDR_W(4)) bus0 ();
  sync_fifo_flags_if #(.WIDTH(64), .ADDR_W(4)) bus1 ();

  sync_fifo_flags #(.WIDTH(64), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  sync_fifo_flags #(.WIDTH(64), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1))
    u1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        push, pop, flush, clr;
    logic [63:0] din;
    logic [4:0]  cnt;
    logic        full, empty, af, ae, ovf, udf, valid;
    logic        chk_d;
    logic [63:0] dout;
  } vec_t;

  vec_t vecs[$];

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic push, pop, flush, clr, input logic [63:0] din,
                              input logic [4:0] cnt, input logic full, empty, af, ae,
                              ovf, udf, valid, chk_d, input logic [63:0] dout);
    vec_t v;
    v.push = push; v.pop = pop; v.flush = flush; v.clr = clr; v.din = din;
    v.cnt = cnt; v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    v.ovf = ovf; v.udf = udf; v.valid = valid; v.chk_d = chk_d; v.dout = dout;
    vecs.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step0(input logic push, pop, flush, clr, input logic [63:0] din);
    bus0.push = push; bus0.pop = pop; bus0.flush = flush; bus0.clr_err = clr;
    bus0.data_in = din;
    @(posedge clk); #1;
    bus0.push = 0; bus0.pop = 0; bus0.flush = 0; bus0.clr_err = 0;
  endtask

  task automatic step1(input logic push, pop, input logic [63:0] din);
    bus1.push = push; bus1.pop = pop; bus1.data_in = din;
    @(posedge clk); #1;
    bus1.push = 0; bus1.pop = 0;
  endtask

  task automatic chk_reset0(input string nm);
    chk({nm, ".count"}, 64'(bus0.count), 64'd0);
    chk({nm, ".empty"}, 64'(bus0.fifo_empty), 64'd1);
    chk({nm, ".ae"},    64'(bus0.almost_empty), 64'd1);
    chk({nm, ".full"},  64'(bus0.fifo_full), 64'd0);
    chk({nm, ".af"},    64'(bus0.almost_full), 64'd0);
    chk({nm, ".ovf"},   64'(bus0.overflow), 64'd0);
    chk({nm, ".udf"},   64'(bus0.underflow), 64'd0);
    chk({nm, ".valid"}, 64'(bus0.data_valid), 64'd0);
    chk({nm, ".dout"},  bus0.data_out, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] d;
    logic [63:0] e;
    bus0.push = 0; bus0.pop = 0; bus0.flush = 0; bus0.clr_err = 0; bus0.data_in = '0;
    bus1.push = 0; bus1.pop = 0; bus1.flush = 0; bus1.clr_err = 0; bus1.data_in = '0;
    rst = 1'b1;
    #12 rst = 1'b0;
    #1;

    chk_reset0("reset");
    chk("reset.fwft_dout",  bus1.data_out, 64'd0);
    chk("reset.fwft_valid", 64'(bus1.data_valid), 64'd0);

    // Vector table: fill, overflow, drain, underflow, clear, set-wins,
    // push+pop at empty. Expected values are post-edge state.
    for (int i = 0; i < 16; i++)
      add(1, 0, 0, 0, 64'(i), 5'(i+1), (i+1 == 16), 0, (i+1 >= 12), (i+1 <= 4),
          0, 0, 0, 0, 64'd0);
    add(1, 0, 0, 0, 64'h99, 5'd16, 1, 0, 1, 0, 1, 0, 0, 0, 64'd0);
    for (int i = 0; i < 16; i++)
      add(0, 1, 0, 0, 64'd0, 5'(15-i), 0, (i == 15), (15-i >= 12), (15-i <= 4),
          1, 0, 1, 1, 64'(i));
    add(0, 1, 0, 0, 64'd0, 5'd0, 0, 1, 0, 1, 1, 1, 0, 1, 64'h0F);
    add(0, 0, 0, 1, 64'd0, 5'd0, 0, 1, 0, 1, 0, 0, 0, 1, 64'h0F);
    add(0, 1, 0, 1, 64'd0, 5'd0, 0, 1, 0, 1, 0, 1, 0, 0, 64'd0);
    add(0, 0, 0, 1, 64'd0, 5'd0, 0, 1, 0, 1, 0, 0, 0, 0, 64'd0);
    add(1, 1, 0, 0, 64'h77, 5'd1, 0, 0, 0, 1, 0, 1, 0, 1, 64'h0F);
    add(0, 0, 0, 1, 64'd0, 5'd1, 0, 0, 0, 1, 0, 0, 0, 0, 64'd0);
    add(0, 1, 0, 0, 64'd0, 5'd0, 0, 1, 0, 1, 0, 0, 1, 1, 64'h77);

    for (int k = 0; k < vecs.size(); k++) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      step0(vecs[k].push, vecs[k].pop, vecs[k].flush, vecs[k].clr, vecs[k].din);
      chk({nm, ".count"}, 64'(bus0.count), 64'(vecs[k].cnt));
      chk({nm, ".full"},  64'(bus0.fifo_full), 64'(vecs[k].full));
      chk({nm, ".empty"}, 64'(bus0.fifo_empty), 64'(vecs[k].empty));
      chk({nm, ".af"},    64'(bus0.almost_full), 64'(vecs[k].af));
      chk({nm, ".ae"},    64'(bus0.almost_empty), 64'(vecs[k].ae));
      chk({nm, ".ovf"},   64'(bus0.overflow), 64'(vecs[k].ovf));
      chk({nm, ".udf"},   64'(bus0.underflow), 64'(vecs[k].udf));
      chk({nm, ".valid"}, 64'(bus0.data_valid), 64'(vecs[k].valid));
      if (vecs[k].chk_d) chk({nm, ".dout"}, bus0.data_out, vecs[k].dout);
    end

    // Full concurrency: push+pop at full keeps count, no overflow.
    for (int i = 0; i < 16; i++) step0(1, 0, 0, 0, 64'h10 + 64'(i));
    chk("conc.fill_count", 64'(bus0.count), 64'd16);
    step0(1, 1, 0, 0, 64'hAA);
    chk("conc.count", 64'(bus0.count), 64'd16);
    chk("conc.full",  64'(bus0.fifo_full), 64'd1);
    chk("conc.ovf",   64'(bus0.overflow), 64'd0);
    chk("conc.dout",  bus0.data_out, 64'h10);
    chk("conc.valid", 64'(bus0.data_valid), 64'd1);
    for (int i = 0; i < 15; i++) begin
      step0(0, 1, 0, 0, 64'd0);
      chk($sformatf("conc.drain%0d", i), bus0.data_out, 64'h11 + 64'(i));
    end
    step0(0, 1, 0, 0, 64'd0);
    chk("conc.last",  bus0.data_out, 64'hAA);
    chk("conc.empty", 64'(bus0.fifo_empty), 64'd1);

    // Wrap-around against a reference queue.
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom};
      exp_q.push_back(d);
      step0(1, 0, 0, 0, d);
    end
    for (int c = 0; c < 40; c++) begin
      logic p, q;
      p = (c % 4 != 1);
      q = (c % 4 != 0);
      d = {$urandom, $urandom};
      e = '0;
      if (q) e = exp_q.pop_front();
      if (p) exp_q.push_back(d);
      step0(p, q, 0, 0, d);
      if (q) chk($sformatf("wrap.dout%0d", c), bus0.data_out, e);
      chk($sformatf("wrap.count%0d", c), 64'(bus0.count), 64'(exp_q.size()));
      chk($sformatf("wrap.err%0d", c), 64'({bus0.overflow, bus0.underflow}), 64'd0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step0(0, 1, 0, 0, 64'd0);
      chk("wrap.drain", bus0.data_out, e);
    end
    chk("wrap.empty", 64'(bus0.fifo_empty), 64'd1);

    // Flush at count=7 with a pending underflow flag.
    step0(0, 1, 0, 0, 64'd0);
    chk("flush.udf_pre", 64'(bus0.underflow), 64'd1);
    for (int i = 0; i < 7; i++) step0(1, 0, 0, 0, 64'h40 + 64'(i));
    chk("flush.count_pre", 64'(bus0.count), 64'd7);
    step0(1, 1, 1, 0, 64'hEE);
    chk("flush.count", 64'(bus0.count), 64'd0);
    chk("flush.empty", 64'(bus0.fifo_empty), 64'd1);
    chk("flush.valid", 64'(bus0.data_valid), 64'd0);
    chk("flush.udf",   64'(bus0.underflow), 64'd1);
    chk("flush.ovf",   64'(bus0.overflow), 64'd0);
    step0(1, 0, 0, 0, 64'h33);
    step0(0, 1, 0, 0, 64'd0);
    chk("flush.next_dout",  bus0.data_out, 64'h33);
    chk("flush.next_count", 64'(bus0.count), 64'd0);
    step0(0, 0, 0, 1, 64'd0);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) step0(1, 0, 0, 0, 64'h80 + 64'(i));
    step0(0, 1, 0, 0, 64'd0);
    chk("arst.pre_dout", bus0.data_out, 64'h80);
    #3 rst = 1'b1;
    #1;
    chk_reset0("arst");
    @(negedge clk);
    rst = 1'b0;
    #1;

    // First-word-fall-through instance.
    step1(1, 0, 64'h55);
    chk("fwft.dout55",  bus1.data_out, 64'h55);
    chk("fwft.valid55", 64'(bus1.data_valid), 64'd1);
    chk("fwft.count1",  64'(bus1.count), 64'd1);
    step1(1, 0, 64'h66);
    chk("fwft.head",    bus1.data_out, 64'h55);
    step1(0, 1, 64'd0);
    chk("fwft.dout66",  bus1.data_out, 64'h66);
    chk("fwft.valid66", 64'(bus1.data_valid), 64'd1);
    step1(0, 1, 64'd0);
    chk("fwft.empty",   64'(bus1.fifo_empty), 64'd1);
    chk("fwft.dout0",   bus1.data_out, 64'd0);
    chk("fwft.valid0",  64'(bus1.data_valid), 64'd0);
    chk("fwft.udf",     64'(bus1.underflow), 64'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
